word_byte_serializer: RTL
=========================

Name: word_byte_serializer

Overview:
- Controller that sequences the 32-bit-to-byte split over time.
- Accepts one 32-bit word plus a 4-bit byte-enable mask over a valid/ready handshake.
- Emits the enabled bytes one per accepted beat on an 8-bit valid/ready stream.
- Sits between a word-wide producer (register file / memory read path) and a byte-wide consumer (UART/display/byte bus).

Parameters:
MSB_FIRST, 1, 1: emit byte lanes in order 3,2,1,0 (bits [31:24] first); 0: emit in order 0,1,2,3.
CNT_W, 16, width of the words_done counter; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  serializer accepts a word this cycle
in_data  input  32  word; lane k = in_data[8k+7:8k]
in_be  input  4  lane enables; bit k set → lane k is emitted
out_valid  output  1  out_data holds a byte
out_ready  input  1  consumer takes the byte
out_data  output  8  current byte
busy  output  1  high while in SEND
word_done  output  1  one-cycle pulse when a word's last byte is accepted, or when an all-zero-mask word is accepted
words_done  output  CNT_W  count of completed words

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE; holding reg and mask = 0.
  - out_valid=0, out_data=0, busy=0, word_done=0, words_done=0.
  - in_ready=1 once reset is released.
- Reset mid-word: the remaining bytes are dropped; no partial output after release.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid with in_be≠0: latch in_data→hold, in_be→mask; go to SEND on the next edge.
    - On in_valid with in_be=0: consume the word, pulse word_done next cycle, increment words_done, stay in IDLE.
  - SEND: busy=1, out_valid=1 (registered).
    - Selected lane = highest set bit of mask if MSB_FIRST, else lowest set bit.
    - out_data = hold byte of the selected lane.
    - out_data is stable while out_valid && !out_ready.
    - On out_valid && out_ready: clear the selected bit.
    - If the cleared bit was the last set bit: word_done pulses next cycle, words_done increments.
      - If in_valid is also high: in_ready=1 this cycle, the new word is loaded, and the block stays in SEND with no bubble (zero-mask new word: handled as in IDLE, then go to IDLE).
      - Otherwise: go to IDLE.
- in_ready is combinational: (state==IDLE) || (SEND && out_ready && mask has exactly one bit set). No other path to in_ready.
- Latency: word accepted at edge N → first byte valid at N+1. Back-to-back full-mask words give 4 beats per word at 100% throughput with out_ready held high.
- out_valid never drops without a handshake.
- words_done wraps from 2^CNT_W-1 to 0.
- in_data/in_be are ignored when in_ready=0.

Optional Feature:
- SER_LAST_EN defined: adds output port out_last (1 bit, reset 0). out_last=1 exactly with the final enabled byte of each word (mask has one bit left) and is held with out_data under backpressure.
- SER_LAST_EN undefined: no out_last port; all other behaviour identical.

Test Plan:
1. Reset then in_data=32'h12345678, in_be=4'hF, out_ready=1, MSB_FIRST=1 → out_data 12,34,56,78 on 4 consecutive cycles; word_done one pulse; words_done=1.
2. Same word, MSB_FIRST=0, in_be=4'b1010 → bytes 56 then 12 only; out_last (SER_LAST_EN) high only on 12.
3. Two words offered back-to-back (AABBCCDD, 11223344, be=F), out_ready=1 → 8 contiguous valid beats, no bubble; in_ready high only on the cycle byte DD / 44 is accepted.
4. out_ready toggled 1,0,0,1,… during a word → out_data/out_valid stable while stalled; byte order and count unchanged.
5. in_be=0 word accepted in IDLE → no out_valid, word_done pulse, words_done+1; with CNT_W=2 after 4 words → words_done=0.
6. Assert rst_n low after 2 of 4 bytes → out_valid=0 immediately (async), words_done=0; after release the next word serializes cleanly.

Source files
------------

// File: rtl/word_byte_serializer.sv
// Serializes a 32-bit word into its enabled bytes on an 8-bit valid/ready stream.
// Optional out_last port is enabled by defining SER_LAST_EN.
module word_byte_serializer #(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [3:0]       in_be,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] words_done
`ifdef SER_LAST_EN
  ,
  output logic             out_last
`endif
);

  // Handshakes on both sides: a transfer happens on a rising edge where valid && ready;
  // out_valid/out_data never change while out_valid && !out_ready.

  typedef enum logic { IDLE = 1'b0, SEND = 1'b1 } state_t;

  state_t      state, state_d;
  logic [31:0] hold, hold_d;
  logic [3:0]  mask, mask_d;
  logic [1:0]  done_cnt;
  logic [1:0]  sel;
  logic        fire, last_one, accept;

  function automatic logic [1:0] sel_lane(input logic [3:0] m);
    logic [1:0] s;
    s = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (MSB_FIRST != 0) begin
        if (m[k]) s = 2'(k);
      end else begin
        if (m[3-k]) s = 2'(3 - k);
      end
    end
    return s;
  endfunction

  assign sel       = sel_lane(mask);
  assign last_one  = (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
  assign fire      = (state == SEND) && out_ready;
  assign in_ready  = (state == IDLE) || (fire && last_one);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_data  = (state == SEND) ? hold[{sel, 3'b000} +: 8] : 8'h00;
`ifdef SER_LAST_EN
  assign out_last  = (state == SEND) && last_one;
`endif

  always_comb begin
    state_d  = state;
    hold_d   = hold;
    mask_d   = mask;
    done_cnt = 2'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_be != 4'd0) begin
            hold_d  = in_data;
            mask_d  = in_be;
            state_d = SEND;
          end else begin
            done_cnt = 2'd1;
          end
        end
      end
      SEND: begin
        if (fire) begin
          mask_d = mask & ~(4'b0001 << sel);
          if (last_one) begin
            done_cnt = 2'd1;
            state_d  = IDLE;
            // A word waiting at the producer is taken on the same edge: no bubble.
            if (accept) begin
              if (in_be != 4'd0) begin
                hold_d  = in_data;
                mask_d  = in_be;
                state_d = SEND;
              end else begin
                done_cnt = 2'd2;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= 32'd0;
      mask       <= 4'd0;
      word_done  <= 1'b0;
      words_done <= '0;
    end else begin
      state      <= state_d;
      hold       <= hold_d;
      mask       <= mask_d;
      word_done  <= (done_cnt != 2'd0);
      words_done <= words_done + CNT_W'(done_cnt);
    end
  end

endmodule
